// File: rtl/alu_deframer_if.sv
// Receive-side bus of the ALU deframer: sender beat stream, length/overflow control
// and the valid/ready word output toward the consumer.
interface alu_deframer_if;
  logic [4:0]  frame_len;
  logic        frame_len_val;
  logic        frame;
  logic [31:0] frame_data;
  logic        frame_bp;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_last;
  logic        rx_ready;
  logic        rx_ovf;
  logic        ovf_clr;
  logic [7:0]  frame_cnt;

  modport slave (
    input  frame_len, frame_len_val, frame, frame_data, rx_ready, ovf_clr,
    output frame_bp, rx_data, rx_valid, rx_last, rx_ovf, frame_cnt
  );

  modport master (
    output frame_len, frame_len_val, frame, frame_data, rx_ready, ovf_clr,
    input  frame_bp, rx_data, rx_valid, rx_last, rx_ovf, frame_cnt
  );
endinterface

// File: rtl/alu_deframer.sv
// Splits the incoming word stream into count-delimited frames, tags the last word,
// and buffers {last, data} in a small FIFO with registered backpressure to the sender.
module alu_deframer #(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  alu_deframer_if.slave bus
);

  localparam int DATA_W = 32;
  localparam int AW     = $clog2(DEPTH);
  localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   THRESH  = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [4:0]  wcnt_q, wcnt_d;
  logic [4:0]  len_q;
  logic [4:0]  pend_len;
  logic        pend_vld;
  logic        beat_last;
  logic        len_direct;

  logic [DATA_W:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     cnt, cnt_next;
  logic            push, pop;
  logic            rx_valid_w;
  logic            frame_bp_q;
  logic            rx_ovf_q;
  logic [7:0]      frame_cnt_q;

  // ---- framing FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // ---- framing FSM: next state; dropped beats advance it too so framing stays aligned
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      IDLE: begin
        if (bus.frame && (len_q != 5'd0)) begin
          state_d = RECV;
          wcnt_d  = 5'd1;
        end
      end
      RECV: begin
        if (bus.frame) begin
          if (wcnt_q == len_q) begin
            state_d = IDLE;
            wcnt_d  = 5'd0;
          end else begin
            wcnt_d  = wcnt_q + 5'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        wcnt_d  = 5'd0;
      end
    endcase
  end

  // ---- framing FSM: outputs
  always_comb begin
    beat_last  = 1'b0;
    len_direct = 1'b0;
    case (state_q)
      IDLE: begin
        beat_last  = bus.frame && (len_q == 5'd0);
        len_direct = bus.frame_len_val && !bus.frame;
      end
      RECV: beat_last = bus.frame && (wcnt_q == len_q);
      default: begin
        beat_last  = 1'b0;
        len_direct = 1'b0;
      end
    endcase
  end

  // ---- length register; a pulse on the completing beat goes straight to the next frame
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q    <= '0;
      pend_vld <= 1'b0;
    end else if (beat_last) begin
      if (bus.frame_len_val) begin
        len_q <= bus.frame_len;
      end else if (pend_vld) begin
        len_q <= pend_len;
      end
      pend_vld <= 1'b0;
    end else if (len_direct) begin
      len_q <= bus.frame_len;
    end else if (bus.frame_len_val) begin
      pend_vld <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.frame_len_val && !beat_last && !len_direct) begin
      pend_len <= bus.frame_len;
    end
  end

  // ---- FIFO control; a full FIFO still accepts a beat when the head leaves in the same cycle
  assign rx_valid_w = (cnt != '0);
  assign pop        = rx_valid_w && bus.rx_ready;
  assign push       = bus.frame && ((cnt != FULL) || pop);

  always_comb begin
    cnt_next = cnt;
    if (push && !pop) begin
      cnt_next = cnt + CNT_ONE;
    end else if (pop && !push) begin
      cnt_next = cnt - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {beat_last, bus.frame_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt         <= '0;
      frame_bp_q  <= 1'b0;
      rx_ovf_q    <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      cnt        <= cnt_next;
      // one slot of headroom covers the beat already in flight when the sender sees bp
      frame_bp_q <= (cnt_next >= THRESH);
      if (bus.frame && !push) begin
        rx_ovf_q <= 1'b1;
      end else if (bus.ovf_clr) begin
        rx_ovf_q <= 1'b0;
      end
      if (push && beat_last) begin
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end
    end
  end

  // ---- outputs; storage is unreset, so the head is masked while the FIFO is empty
  assign bus.rx_valid  = rx_valid_w;
  assign bus.rx_data   = rx_valid_w ? mem[rd_ptr][DATA_W-1:0] : '0;
  assign bus.rx_last   = rx_valid_w ? mem[rd_ptr][DATA_W] : 1'b0;
  assign bus.frame_bp  = frame_bp_q;
  assign bus.rx_ovf    = rx_ovf_q;
  assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_alu_deframer.sv
// Self-checking bench for alu_deframer: vector table for the single frame, scoreboard
// of {last, data} for every accepted word, and hand-written multi-cycle sequences.
module tb_alu_deframer;

  logic clk;
  logic rst;

  alu_deframer_if bus ();

  alu_deframer #(.DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        frm;
    logic [31:0] d;
    logic        rdy;
    logic        e_vld;
    logic [31:0] e_data;
    logic        e_last;
    logic        e_bp;
  } vec_t;

  vec_t        vt [5];
  logic [32:0] sb [$];
  int          n_tests;
  int          n_fail;
  int          n_rx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Compare a handshake against the scoreboard, then advance one clock; inputs change at negedge.
  task automatic step();
    logic [32:0] e;
    if (!rst && bus.rx_valid && bus.rx_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_underflow: got word %0h, required no word", bus.rx_data);
      end else begin
        e = sb.pop_front();
        check("sb_data", bus.rx_data, e[31:0]);
        check("sb_last", 32'(bus.rx_last), 32'(e[32]));
      end
      n_rx++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic beat(input logic [31:0] d, input logic last, input logic keep);
    bus.frame      = 1'b1;
    bus.frame_data = d;
    if (keep) sb.push_back({last, d});
    step();
    bus.frame      = 1'b0;
  endtask

  task automatic load_len(input logic [4:0] v);
    bus.frame_len     = v;
    bus.frame_len_val = 1'b1;
    step();
    bus.frame_len_val = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    int c;
    bus.frame    = 1'b0;
    bus.rx_ready = 1'b1;
    c = 0;
    while (sb.size() != 0 && c < max_cyc) begin
      step();
      c++;
    end
    check("drain_left", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_bp"},    32'(bus.frame_bp), 32'd0);
    check({tag, "_valid"}, 32'(bus.rx_valid), 32'd0);
    check({tag, "_last"},  32'(bus.rx_last),  32'd0);
    check({tag, "_data"},  bus.rx_data,       32'd0);
    check({tag, "_ovf"},   32'(bus.rx_ovf),   32'd0);
    check({tag, "_fcnt"},  32'(bus.frame_cnt), 32'd0);
  endtask

  initial begin
    int n_rx0;
    int sent;
    int cyc;
    logic bp_lag;
    logic bp_seen;

    n_tests = 0;
    n_fail  = 0;
    n_rx    = 0;
    rst               = 1'b1;
    bus.frame_len     = '0;
    bus.frame_len_val = 1'b0;
    bus.frame         = 1'b0;
    bus.frame_data    = '0;
    bus.rx_ready      = 1'b0;
    bus.ovf_clr       = 1'b0;

    for (int i = 0; i < 4; i++) begin
      vt[i] = '{1'b1, 32'hA0 + 32'(i), 1'b1, 1'b1, 32'hA0 + 32'(i), (i == 3), 1'b0};
    end
    vt[4] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0};

    step();
    step();
    rst = 1'b0;
    check_reset_vals("rst0");

    // Single frame of 4 words, consumer always ready
    load_len(5'd3);
    for (int i = 0; i < 5; i++) begin
      bus.frame      = vt[i].frm;
      bus.frame_data = vt[i].d;
      bus.rx_ready   = vt[i].rdy;
      if (vt[i].frm) sb.push_back({vt[i].e_last, vt[i].d});
      step();
      check("tbl_valid", 32'(bus.rx_valid), 32'(vt[i].e_vld));
      check("tbl_bp",    32'(bus.frame_bp), 32'(vt[i].e_bp));
      if (vt[i].e_vld) begin
        check("tbl_data", bus.rx_data, vt[i].e_data);
        check("tbl_last", 32'(bus.rx_last), 32'(vt[i].e_last));
      end
    end
    bus.frame = 1'b0;
    check("single_fcnt", 32'(bus.frame_cnt), 32'd1);
    check("single_sb", 32'(sb.size()), 32'd0);

    // Backpressure: 16-word frame, stalled consumer, sender reacting one cycle late
    load_len(5'd15);
    bus.rx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      beat(32'hB00 + 32'(i), 1'b0, 1'b1);
      check("bp_rise", 32'(bus.frame_bp), 32'(i == 2));
    end
    beat(32'hB03, 1'b0, 1'b1);
    check("bp_inflight", 32'(bus.frame_bp), 32'd1);
    check("bp_no_ovf", 32'(bus.rx_ovf), 32'd0);
    step();
    check("bp_hold_valid", 32'(bus.rx_valid), 32'd1);
    check("bp_hold_data", bus.rx_data, 32'hB00);
    n_rx0 = n_rx;
    bus.rx_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check("bp_buffered", 32'(n_rx - n_rx0), 32'd4);
    sent    = 4;
    cyc     = 0;
    bp_lag  = bus.frame_bp;
    bp_seen = 1'b0;
    while (sent < 16 && cyc < 100) begin
      if (!bp_lag) begin
        bus.frame      = 1'b1;
        bus.frame_data = 32'hB00 + 32'(sent);
        sb.push_back({(sent == 15), 32'hB00 + 32'(sent)});
        sent++;
      end else begin
        bus.frame = 1'b0;
      end
      step();
      bp_lag  = bus.frame_bp;
      bp_seen = bp_seen | bus.frame_bp;
      cyc++;
    end
    bus.frame = 1'b0;
    check("bp_sent", 32'(sent), 32'd16);
    check("bp_stream_nobp", 32'(bp_seen), 32'd0);
    drain(20);
    check("bp_total", 32'(n_rx - n_rx0), 32'd16);
    check("bp_ovf", 32'(bus.rx_ovf), 32'd0);
    check("bp_fcnt", 32'(bus.frame_cnt), 32'd2);

    // Overflow: 6 beats into a stalled 4-deep FIFO; clear coinciding with a drop keeps the flag
    load_len(5'd7);
    bus.rx_ready = 1'b0;
    for (int i = 0; i < 4; i++) beat(32'hC0 + 32'(i), 1'b0, 1'b1);
    check("ovf_before", 32'(bus.rx_ovf), 32'd0);
    beat(32'hC4, 1'b0, 1'b0);
    check("ovf_set", 32'(bus.rx_ovf), 32'd1);
    bus.ovf_clr = 1'b1;
    beat(32'hC5, 1'b0, 1'b0);
    bus.ovf_clr = 1'b0;
    check("ovf_clr_collide", 32'(bus.rx_ovf), 32'd1);
    check("ovf_head", bus.rx_data, 32'hC0);
    check("ovf_fcnt_mid", 32'(bus.frame_cnt), 32'd2);
    bus.ovf_clr = 1'b1;
    step();
    bus.ovf_clr = 1'b0;
    check("ovf_cleared", 32'(bus.rx_ovf), 32'd0);
    n_rx0 = n_rx;
    drain(10);
    check("ovf_retained", 32'(n_rx - n_rx0), 32'd4);
    beat(32'hC6, 1'b0, 1'b1);
    beat(32'hC7, 1'b1, 1'b1);
    drain(10);
    check("ovf_fcnt", 32'(bus.frame_cnt), 32'd3);

    // Length change mid-frame: current frame keeps 8 words, next ones use 2
    bus.rx_ready = 1'b1;
    load_len(5'd7);
    beat(32'hD0, 1'b0, 1'b1);
    beat(32'hD1, 1'b0, 1'b1);
    bus.frame_len     = 5'd1;
    bus.frame_len_val = 1'b1;
    step();
    bus.frame_len_val = 1'b0;
    for (int i = 2; i < 8; i++) beat(32'hD0 + 32'(i), (i == 7), 1'b1);
    check("lenchg_fcnt1", 32'(bus.frame_cnt), 32'd4);
    beat(32'hE0, 1'b0, 1'b1);
    beat(32'hE1, 1'b1, 1'b1);
    beat(32'hE2, 1'b0, 1'b1);
    beat(32'hE3, 1'b1, 1'b1);
    drain(10);
    check("lenchg_fcnt", 32'(bus.frame_cnt), 32'd6);

    // 1-word frames on alternate cycles until frame_cnt wraps
    load_len(5'd0);
    for (int k = 1; k <= 250; k++) begin
      beat(32'h1000 + 32'(k), 1'b1, 1'b1);
      check("w1_fcnt", 32'(bus.frame_cnt), 32'((6 + k) % 256));
      step();
    end
    check("w1_wrap", 32'(bus.frame_cnt), 32'd0);
    for (int k = 0; k < 3; k++) beat(32'h2000 + 32'(k), 1'b1, 1'b1);
    drain(10);
    check("w1_fcnt_post", 32'(bus.frame_cnt), 32'd3);

    // Reset mid-frame with a pending length; partial frame and pending value are discarded
    load_len(5'd3);
    bus.rx_ready = 1'b0;
    beat(32'hF0, 1'b0, 1'b0);
    beat(32'hF1, 1'b0, 1'b0);
    bus.frame_len     = 5'd2;
    bus.frame_len_val = 1'b1;
    step();
    bus.frame_len_val = 1'b0;
    check("pre_rst_valid", 32'(bus.rx_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_vals("rst1");
    bus.rx_ready = 1'b1;
    for (int i = 0; i < 4; i++) beat(32'h3000 + 32'(i), 1'b1, 1'b1);
    drain(10);
    check("rst_fcnt", 32'(bus.frame_cnt), 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_deframer.md
# alu_deframer

Receive-side counterpart of the ALU framer. Accepts the 32-bit word stream driven on `frame`/`frame_data`, splits it into frames of programmed length, and buffers words in a small FIFO. Words are presented to a downstream consumer with a valid/ready handshake and a last-word marker. The upstream sender is throttled through `frame_bp`.

## Interface
- `DEPTH`, default 4: FIFO depth in words; power of two, minimum 4.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `frame_len` in 5: programmed frame length minus one, so a frame is `frame_len`+1 words (1..32).
- `frame_len_val` in 1: strobe that loads `frame_len`.
- `frame` in 1: beat valid; `frame_data` carries one word in every cycle where `frame` is high.
- `frame_data` in 32: beat payload.
- `frame_bp` out 1: backpressure to the sender; registered.
- `rx_data` out 32: head-of-FIFO word.
- `rx_valid` out 1: `rx_data` is valid.
- `rx_last` out 1: `rx_data` is the final word of its frame.
- `rx_ready` in 1: consumer accepts the word when `rx_valid` and `rx_ready` are both high.
- `rx_ovf` out 1: sticky overflow flag; a beat was dropped.
- `ovf_clr` in 1: clears `rx_ovf`.
- `frame_cnt` out 8: count of completed frames accepted into the FIFO; wraps from 255 to 0.

## Operation
- **Length register**
  - `len_q` resets to 0, which gives 1-word frames.
  - A `frame_len_val` pulse while the FSM is in IDLE loads `len_q` on the next edge.
  - A pulse while in RECV is held in a single pending slot, and the last value written wins. The pending value is applied on the edge that completes the current frame, so the next frame uses it.
- **FSM, IDLE state**
  - A beat moves the FSM to RECV, with `wcnt` = 1.
  - If `len_q` = 0, the beat is last; the FSM stays in IDLE and `frame_cnt` increments.
- **FSM, RECV state**
  - Each beat increments `wcnt`.
  - The beat accepted when `wcnt` = `len_q` is tagged last. On that beat the FSM returns to IDLE, `wcnt` returns to 0 and `frame_cnt` increments.
- **Gaps and boundaries**
  - Frames are delimited by count only.
  - Gaps (`frame` low) are legal anywhere, including mid-frame. In a gap `wcnt` holds.
- **FIFO**
  - The FIFO holds 33 bits per entry: data plus the last tag.
  - Occupancy `cnt` ranges 0..DEPTH.
  - A push happens on a beat when `cnt` < DEPTH, or when `cnt` = DEPTH and a pop occurs in the same cycle.
  - A pop happens on `rx_valid`&`rx_ready`.
  - A simultaneous push and pop leaves `cnt` unchanged.
- **Overflow**
  - A beat with no space is dropped and `rx_ovf` is set.
  - The FSM and `wcnt` still advance on a dropped beat, so framing stays aligned.
  - `frame_cnt` counts a frame only if its last beat was pushed.
  - If `ovf_clr` and a new overflow occur in the same cycle, `rx_ovf` ends up set.
- **Backpressure:** registered `frame_bp` = (`cnt_next` >= DEPTH-1), recomputed every cycle.
- **Reset mid-operation**
  - FIFO is emptied, the FSM returns to IDLE, `wcnt` = 0, and `len_q` = 0.
  - The pending length is discarded, and `rx_ovf` and `frame_cnt` are cleared.
  - A partial frame is lost.

## Timing
- **Reset values:** `frame_bp`=0, `rx_valid`=0, `rx_last`=0, `rx_data`=0, `rx_ovf`=0, `frame_cnt`=0.
- **Latency**
  - A beat pushed at edge N into an empty FIFO shows `rx_valid`=1 from after edge N. There is one cycle of latency, with no bypass.
  - `rx_data` and `rx_last` are driven from FIFO storage and hold stable while `rx_valid`&!`rx_ready`.
- **Sender contract**
  - The sender samples `frame_bp` and must stop sending no later than one cycle after `frame_bp` rises.
  - The DEPTH-1 threshold leaves exactly one slot for that in-flight beat, so a compliant sender never overflows.
- **Throughput:** with `rx_ready` held high, a continuous stream runs at one word per cycle and `frame_bp` never asserts.
- **`frame_len_val` timing:** a pulse in the same cycle as the IDLE to RECV beat is treated as arriving in RECV, so it becomes pending.

## Test plan
- **Single frame:** reset, `frame_len`=3 loaded, 4 back-to-back beats 0xA0..0xA3, `rx_ready`=1.
  - Required: the same 4 words appear one cycle later, with `rx_last` only on 0xA3.
  - Required: `frame_cnt`=1 and `frame_bp` stays 0.
- **Backpressure:** DEPTH=4, `rx_ready`=0, compliant sender streaming a 16-word frame.
  - Required: `frame_bp` rises after the 3rd push and exactly 4 words are buffered.
  - Required: after releasing `rx_ready`, all 16 words arrive in order and `rx_ovf`=0.
- **Overflow:** `rx_ready`=0, a noncompliant sender sends 6 beats.
  - Required: words 1-4 are retained, `rx_ovf`=1, and the FSM `wcnt`=6.
  - Required: pulsing `ovf_clr` clears `rx_ovf`.
- **Length change mid-frame:** `frame_len`=7 loaded, 2 beats sent, then a pulse with `frame_len`=1.
  - Required: the current frame still ends at its 8th beat.
  - Required: the next frame ends at its 2nd beat (`rx_last`).
- **1-word frames with gaps:** `frame_len`=0, beats sent on alternate cycles.
  - Required: every word has `rx_last`=1 and `frame_cnt` increments per beat.
  - Required: `frame_cnt` wraps to 0 after 256 frames.
- **Reset mid-frame:** `frame_len`=3, 2 beats, `rst` pulsed, then 4 new beats.
  - Required: all outputs are at their reset values the cycle after reset.
  - Required: the post-reset frame is treated as 1-word frames (`len_q`=0), giving 4 `rx_last` words and `frame_cnt`=4.
